issue_queue_mc: RTL and testbench
=================================

Name: issue_queue_mc

Overview:
- Parametrised in-order reservation queue for the Tomasulo core; successor of the 3-entry single-operand queue.
- Holds up to DEPTH instructions, each with NUM_SRC source operands. Every waiting operand snoops NUM_BC result broadcast buses.
- Issues the head entry to its functional unit once all its operands are ready.
- Allocates a unique result tag per entry. The tag is recycled only when a broadcast carrying that tag is seen.

Parameters:
- DEPTH, 4, entry count; power of 2, at least 2
- DATA_W, 32, operand width
- TAG_W, 4, tag width; tag 0 means "value present"
- OP_W, 2, opcode width
- NUM_SRC, 2, source operands per entry
- NUM_BC, 2, broadcast channels
- ID_BASE, 1, first result tag owned; tags ID_BASE..ID_BASE+DEPTH-1, must be nonzero and fit TAG_W

Ports:
- clk  in  1  clock, rising edge
- RST  in  1  asynchronous active-high reset
- flush  in  1  synchronous clear of queue and tag pool
- enq_valid  in  1  enqueue request
- enq_ready  out  1  enqueue accepted this cycle if enq_valid
- enq_op  in  OP_W  opcode
- enq_val  in  NUM_SRC*DATA_W  operand values, src k at bits [k*DATA_W +: DATA_W]
- enq_tag  in  NUM_SRC*TAG_W  producer tags, 0 = value valid
- enq_id  out  TAG_W  tag allocated to the entry enqueued this cycle
- bc_valid  in  NUM_BC  broadcast strobes
- bc_tag  in  NUM_BC*TAG_W  broadcast tags
- bc_data  in  NUM_BC*DATA_W  broadcast values
- iss_valid  out  1  head entry ready to issue
- iss_ready  in  1  functional unit accepts
- iss_op  out  OP_W  head opcode
- iss_val  out  NUM_SRC*DATA_W  head operands
- iss_id  out  TAG_W  head result tag
- count  out  $clog2(DEPTH)+1  occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Storage and pointers:
  - Circular buffer with head and tail pointers of $clog2(DEPTH) bits; pointers wrap naturally.
  - A separate count register drives full and empty.
- Reset (RST high, async):
  - count=0, pointers=0, all entries invalid.
  - Tag pool all free; outputs iss_valid=0, enq_ready=1, full=0, empty=1.
  - Entry data fields are cleared to 0.
- Tag pool:
  - DEPTH-bit busy map, bit k = tag ID_BASE+k.
  - enq_id is the lowest free tag, combinational.
  - A tag is set busy on enqueue fire. It is cleared when any bc_valid[c] has bc_tag[c]==that tag.
  - A tag freed in cycle N is allocatable from N+1.
- Handshakes:
  - iss_fire = iss_valid && iss_ready.
  - enq_ready = tag_free_exists && (!full || iss_fire).
  - A full queue accepts an enqueue in the same cycle as an issue; this is a combinational path from iss_ready to enq_ready.
  - enq_fire = enq_valid && enq_ready.
- Issue readiness:
  - iss_valid = !empty && all NUM_SRC head tags == 0.
  - Head outputs come straight from registers; zero latency.
- Snooping:
  - Each valid entry's operand k with tag T≠0 is watched.
  - If bc_valid[c] && bc_tag[c]==T, the entry latches bc_data[c] and sets its tag to 0 at the clock edge.
  - If several channels match, the lowest c wins; this is illegal upstream and not asserted.
  - The head's operand becomes ready in the cycle after the broadcast. No same-cycle bypass to iss_val.
- Enqueue capture:
  - An incoming operand with enq_tag matching a same-cycle broadcast is stored as value with tag 0.
  - Otherwise enq_val/enq_tag are stored as given.
  - Effective issue latency for a fully ready enqueue: 1 cycle (entry visible next cycle).
- Simultaneous enq_fire and iss_fire: count unchanged, both pointers advance.
- Flush:
  - Priority over enq and issue; nothing fires in a flush cycle.
  - Next cycle: empty, pointers 0, tag pool all free.
  - Broadcasts in the flush cycle are ignored.
- Count arithmetic: count += enq_fire - iss_fire, evaluated at DEPTH+1 range without overflow.

Optional Feature:
- IQ_STATS_EN defined:
  - Adds outputs stall_full_cnt[31:0] and stall_dep_cnt[31:0].
  - stall_full_cnt increments when enq_valid && !enq_ready.
  - stall_dep_cnt increments when !empty && !iss_valid.
  - Both saturate at all-ones; cleared by RST only, not by flush.
- Undefined: the counter outputs and their logic are absent.

Decomposition:
- Shared package iq_pkg holds:
  - the entry struct (valid, op, val[NUM_SRC], tag[NUM_SRC], id);
  - the TAG_NONE=0 constant;
  - a function for lowest-set-bit index.
- One natural sub-module, iq_tag_pool: busy map, lowest-free encoder, broadcast release.

Test Plan:
1. RST pulse mid-traffic with 3 entries held → next edge count=0, empty=1, enq_ready=1, iss_valid=0; first enq_id=1.
2. Enqueue op=2, vals 5/7, tags 0/0, iss_ready=1 → iss_valid next cycle, iss_val=5/7, iss_id=1, count back to 0 after fire.
3. Enqueue src0 tag=9; two cycles later bc_valid[1]=1, bc_tag[1]=9, bc_data[1]=0xAA → head src0=0xAA, iss_valid asserted the cycle after the broadcast.
4. Fill 4 entries (ids 1..4), iss_ready=0 → full=1, enq_ready=0. Raise iss_ready with head ready and a tag freed → enq and issue in one cycle, count stays 4.
5. Enqueue with enq_tag=6 while bc_tag[0]=6, bc_data[0]=0x33 → entry stored ready with value 0x33, no stall.
6. Flush with 2 entries and ids 1,2 busy → next cycle empty=1, next enq_id=1. Under IQ_STATS_EN, 3 blocked enqueue cycles give stall_full_cnt=3.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared types for the multi-operand issue queue: default configuration,
// the queue entry layout and a lowest-set-bit helper.
package iq_pkg;

    localparam int IQ_DEPTH   = 4;
    localparam int IQ_DATA_W  = 32;
    localparam int IQ_TAG_W   = 4;
    localparam int IQ_OP_W    = 2;
    localparam int IQ_NUM_SRC = 2;
    localparam int IQ_NUM_BC  = 2;
    localparam int IQ_ID_BASE = 1;

    // A zero tag marks an operand whose value is already present.
    localparam logic [IQ_TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic                                   valid;
        logic [IQ_OP_W-1:0]                     op;
        logic [IQ_NUM_SRC-1:0][IQ_DATA_W-1:0]   val;
        logic [IQ_NUM_SRC-1:0][IQ_TAG_W-1:0]    tag;
        logic [IQ_TAG_W-1:0]                    id;
    } iq_entry_t;

    // Index of the lowest set bit; 0 when the vector is all zeros.
    function automatic int unsigned lowest_set(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/iq_tag_pool.sv
// Result-tag allocator: a busy map over tags ID_BASE..ID_BASE+DEPTH-1,
// handing out the lowest free tag and releasing tags seen on a broadcast.
module iq_tag_pool
    import iq_pkg::*;
#(
    parameter int DEPTH   = IQ_DEPTH,
    parameter int TAG_W   = IQ_TAG_W,
    parameter int NUM_BC  = IQ_NUM_BC,
    parameter int ID_BASE = IQ_ID_BASE
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic                    flush,
    input  logic                    alloc,
    input  logic [NUM_BC-1:0]       bc_valid,
    input  logic [NUM_BC*TAG_W-1:0] bc_tag,
    output logic                    free_exists,
    output logic [TAG_W-1:0]        free_id
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] rel_mask;
    logic [DEPTH-1:0] alloc_mask;
    logic [31:0]      free_vec;
    logic [31:0]      free_idx;

    always_comb begin
        free_vec = '0;
        free_vec[DEPTH-1:0] = ~busy;
    end

    assign free_idx    = lowest_set(free_vec);
    assign free_exists = |(~busy);
    assign free_id     = TAG_W'(ID_BASE + int'(free_idx));
    assign alloc_mask  = alloc ? (DEPTH'(1) << free_idx) : '0;

    always_comb begin
        rel_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            for (int c = 0; c < NUM_BC; c++) begin
                if (bc_valid[c] && (bc_tag[c*TAG_W +: TAG_W] == TAG_W'(ID_BASE + k))) begin
                    rel_mask[k] = 1'b1;
                end
            end
        end
    end

    // Allocation wins over a release of the same bit; a released tag is
    // only visible as free from the following cycle.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~rel_mask) | alloc_mask;
        end
    end

endmodule

// File: rtl/issue_queue_mc.sv
// In-order reservation queue with NUM_SRC snooping operands per entry.
// Optional stall counters are built when IQ_STATS_EN is defined.
module issue_queue_mc
    import iq_pkg::*;
#(
    parameter int DEPTH   = IQ_DEPTH,
    parameter int DATA_W  = IQ_DATA_W,
    parameter int TAG_W   = IQ_TAG_W,
    parameter int OP_W    = IQ_OP_W,
    parameter int NUM_SRC = IQ_NUM_SRC,
    parameter int NUM_BC  = IQ_NUM_BC,
    parameter int ID_BASE = IQ_ID_BASE
) (
    input  logic                      clk,
    input  logic                      RST,
    input  logic                      flush,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [OP_W-1:0]           enq_op,
    input  logic [NUM_SRC*DATA_W-1:0] enq_val,
    input  logic [NUM_SRC*TAG_W-1:0]  enq_tag,
    output logic [TAG_W-1:0]          enq_id,
    input  logic [NUM_BC-1:0]         bc_valid,
    input  logic [NUM_BC*TAG_W-1:0]   bc_tag,
    input  logic [NUM_BC*DATA_W-1:0]  bc_data,
    output logic                      iss_valid,
    input  logic                      iss_ready,
    output logic [OP_W-1:0]           iss_op,
    output logic [NUM_SRC*DATA_W-1:0] iss_val,
    output logic [TAG_W-1:0]          iss_id,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
`ifdef IQ_STATS_EN
    ,
    output logic [31:0]               stall_full_cnt,
    output logic [31:0]               stall_dep_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    iq_entry_t        q      [DEPTH];
    iq_entry_t        q_next [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;
    logic             head_ready;
    logic             iss_fire;
    logic             enq_fire;
    logic             tag_free;
    logic [TAG_W-1:0] new_id;

    // Returns {hit, data}; scanning downward lets the lowest channel win.
    function automatic logic [DATA_W:0] snoop(
        input logic [TAG_W-1:0]         t,
        input logic [NUM_BC-1:0]        v,
        input logic [NUM_BC*TAG_W-1:0]  bt,
        input logic [NUM_BC*DATA_W-1:0] bd
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int c = NUM_BC - 1; c >= 0; c--) begin
            if (v[c] && (t != TAG_NONE) && (bt[c*TAG_W +: TAG_W] == t)) begin
                r = {1'b1, bd[c*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    iq_tag_pool #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .NUM_BC  (NUM_BC),
        .ID_BASE (ID_BASE)
    ) u_tag_pool (
        .clk         (clk),
        .RST         (RST),
        .flush       (flush),
        .alloc       (enq_fire),
        .bc_valid    (bc_valid),
        .bc_tag      (bc_tag),
        .free_exists (tag_free),
        .free_id     (new_id)
    );

    assign count = cnt;
    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

    always_comb begin
        head_ready = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (q[head].tag[k] != TAG_NONE) begin
                head_ready = 1'b0;
            end
        end
    end

    // A full queue may accept while the head leaves, so enq_ready depends
    // combinationally on iss_ready.
    assign iss_valid = !empty && head_ready;
    assign iss_fire  = iss_valid && iss_ready && !flush;
    assign enq_ready = tag_free && (!full || iss_fire);
    assign enq_fire  = enq_valid && enq_ready && !flush;
    assign enq_id    = new_id;

    assign iss_op  = q[head].op;
    assign iss_val = q[head].val;
    assign iss_id  = q[head].id;

    // Snoop waiting operands, retire the head, then write the new tail;
    // the write goes last because a full queue reuses the head slot.
    always_comb begin
        logic [DATA_W:0] hit;
        hit    = '0;
        q_next = q;
        for (int i = 0; i < DEPTH; i++) begin
            if (q[i].valid) begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    hit = snoop(q[i].tag[k], bc_valid, bc_tag, bc_data);
                    if (hit[DATA_W]) begin
                        q_next[i].val[k] = hit[DATA_W-1:0];
                        q_next[i].tag[k] = TAG_NONE;
                    end
                end
            end
        end
        if (iss_fire) begin
            q_next[head].valid = 1'b0;
        end
        if (enq_fire) begin
            q_next[tail].valid = 1'b1;
            q_next[tail].op    = enq_op;
            q_next[tail].id    = new_id;
            for (int k = 0; k < NUM_SRC; k++) begin
                hit = snoop(enq_tag[k*TAG_W +: TAG_W], bc_valid, bc_tag, bc_data);
                if (hit[DATA_W]) begin
                    q_next[tail].val[k] = hit[DATA_W-1:0];
                    q_next[tail].tag[k] = TAG_NONE;
                end else begin
                    q_next[tail].val[k] = enq_val[k*DATA_W +: DATA_W];
                    q_next[tail].tag[k] = enq_tag[k*TAG_W +: TAG_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            q <= q_next;
            if (iss_fire) begin
                head <= head + PTR_W'(1);
            end
            if (enq_fire) begin
                tail <= tail + PTR_W'(1);
            end
            if (enq_fire && !iss_fire) begin
                cnt <= cnt + CNT_W'(1);
            end else if (iss_fire && !enq_fire) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

`ifdef IQ_STATS_EN
    // Saturating stall counters survive a flush; only RST clears them.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            stall_full_cnt <= '0;
            stall_dep_cnt  <= '0;
        end else begin
            if (enq_valid && !enq_ready && (stall_full_cnt != '1)) begin
                stall_full_cnt <= stall_full_cnt + 32'd1;
            end
            if (!empty && !iss_valid && (stall_dep_cnt != '1)) begin
                stall_dep_cnt <= stall_dep_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_issue_queue_mc.sv
// Self-checking bench for issue_queue_mc: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_issue_queue_mc;

    localparam int DEPTH   = 4;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 4;
    localparam int OP_W    = 2;
    localparam int NUM_SRC = 2;
    localparam int NUM_BC  = 2;
    localparam int ID_BASE = 1;

    logic                      clk = 1'b0;
    logic                      RST;
    logic                      flush;
    logic                      enq_valid;
    logic                      enq_ready;
    logic [OP_W-1:0]           enq_op;
    logic [NUM_SRC*DATA_W-1:0] enq_val;
    logic [NUM_SRC*TAG_W-1:0]  enq_tag;
    logic [TAG_W-1:0]          enq_id;
    logic [NUM_BC-1:0]         bc_valid;
    logic [NUM_BC*TAG_W-1:0]   bc_tag;
    logic [NUM_BC*DATA_W-1:0]  bc_data;
    logic                      iss_valid;
    logic                      iss_ready;
    logic [OP_W-1:0]           iss_op;
    logic [NUM_SRC*DATA_W-1:0] iss_val;
    logic [TAG_W-1:0]          iss_id;
    logic [$clog2(DEPTH):0]    count;
    logic                      full;
    logic                      empty;
`ifdef IQ_STATS_EN
    logic [31:0]               stall_full_cnt;
    logic [31:0]               stall_dep_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    issue_queue_mc dut (
        .clk       (clk),
        .RST       (RST),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_op    (enq_op),
        .enq_val   (enq_val),
        .enq_tag   (enq_tag),
        .enq_id    (enq_id),
        .bc_valid  (bc_valid),
        .bc_tag    (bc_tag),
        .bc_data   (bc_data),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_op    (iss_op),
        .iss_val   (iss_val),
        .iss_id    (iss_id),
        .count     (count),
        .full      (full),
        .empty     (empty)
`ifdef IQ_STATS_EN
        ,
        .stall_full_cnt (stall_full_cnt),
        .stall_dep_cnt  (stall_dep_cnt)
`endif
    );

    typedef struct {
        logic        ev;
        logic [1:0]  op;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [3:0]  t0;
        logic [3:0]  t1;
        logic [1:0]  bcv;
        logic [3:0]  bt0;
        logic [31:0] bd0;
        logic [3:0]  bt1;
        logic [31:0] bd1;
        logic        ir;
        int          x_cnt;
        logic        x_iv;
        logic        x_er;
        logic [3:0]  x_eid;
        logic [1:0]  x_op;
        logic [31:0] x_v0;
        logic [31:0] x_v1;
        logic [3:0]  x_iid;
    } vec_t;

    typedef struct {
        logic [1:0]        op;
        logic [1:0][31:0]  v;
        logic [1:0][3:0]   t;
        logic [3:0]        id;
    } m_entry_t;

    vec_t       vecs [10];
    m_entry_t   mq [$];
    bit [15:0]  m_busy;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(
        input logic ev, input logic [1:0] op, input logic [31:0] v0, input logic [31:0] v1,
        input logic [3:0] t0, input logic [3:0] t1, input logic [1:0] bcv,
        input logic [3:0] bt0, input logic [31:0] bd0, input logic [3:0] bt1, input logic [31:0] bd1,
        input logic ir, input logic fl
    );
        enq_valid = ev;
        enq_op    = op;
        enq_val   = {v1, v0};
        enq_tag   = {t1, t0};
        bc_valid  = bcv;
        bc_tag    = {bt1, bt0};
        bc_data   = {bd1, bd0};
        iss_ready = ir;
        flush     = fl;
    endtask

    task automatic clear_inputs();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(posedge clk);
        #2 RST = 1'b1;
        #3 RST = 1'b0;
    endtask

    function automatic bit m_snoop(input logic [3:0] t, output logic [31:0] d);
        d = '0;
        if (t == 4'd0) return 1'b0;
        for (int c = 0; c < NUM_BC; c++) begin
            if (bc_valid[c] && bc_tag[c*TAG_W +: TAG_W] == t) begin
                d = bc_data[c*DATA_W +: DATA_W];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    initial begin
        RST = 1'b1;
        clear_inputs();

        // Directed vector table: expected values are what is visible in the
        // same cycle the row's inputs are applied, before the clock edge.
        vecs[0] = '{1,2,32'h5,32'h7,0,0,0,0,0,0,0,1,      0,0,1,1, 0,0,0,0};
        vecs[1] = '{0,0,0,0,0,0,0,0,0,0,0,1,              1,1,1,2, 2,32'h5,32'h7,1};
        vecs[2] = '{1,1,32'h10,32'h11,9,0,0,0,0,0,0,1,    0,0,1,2, 0,0,0,0};
        vecs[3] = '{0,0,0,0,0,0,0,0,0,0,0,1,              1,0,1,3, 0,0,0,0};
        vecs[4] = '{0,0,0,0,0,0,2'b10,0,0,9,32'hAA,1,     1,0,1,3, 0,0,0,0};
        vecs[5] = '{0,0,0,0,0,0,0,0,0,0,0,1,              1,1,1,3, 1,32'hAA,32'h11,2};
        vecs[6] = '{1,3,32'h1,32'h2,6,0,2'b01,6,32'h33,0,0,1, 0,0,1,3, 0,0,0,0};
        vecs[7] = '{0,0,0,0,0,0,0,0,0,0,0,1,              1,1,1,4, 3,32'h33,32'h2,3};
        vecs[8] = '{0,0,0,0,0,0,2'b11,1,0,2,0,1,          0,0,1,4, 0,0,0,0};
        vecs[9] = '{0,0,0,0,0,0,0,0,0,0,0,1,              0,0,1,1, 0,0,0,0};

        do_reset();
        for (int r = 0; r < 10; r++) begin
            tick();
            apply_stimulus(vecs[r].ev, vecs[r].op, vecs[r].v0, vecs[r].v1, vecs[r].t0, vecs[r].t1,
                           vecs[r].bcv, vecs[r].bt0, vecs[r].bd0, vecs[r].bt1, vecs[r].bd1,
                           vecs[r].ir, 1'b0);
            #1;
            check_output($sformatf("vec%0d count", r), 64'(count), 64'(vecs[r].x_cnt));
            check_output($sformatf("vec%0d iss_valid", r), 64'(iss_valid), 64'(vecs[r].x_iv));
            check_output($sformatf("vec%0d enq_ready", r), 64'(enq_ready), 64'(vecs[r].x_er));
            check_output($sformatf("vec%0d enq_id", r), 64'(enq_id), 64'(vecs[r].x_eid));
            if (vecs[r].x_iv) begin
                check_output($sformatf("vec%0d iss_op", r), 64'(iss_op), 64'(vecs[r].x_op));
                check_output($sformatf("vec%0d iss_val", r), 64'(iss_val), {vecs[r].x_v1, vecs[r].x_v0});
                check_output($sformatf("vec%0d iss_id", r), 64'(iss_id), 64'(vecs[r].x_iid));
            end
        end

        // Async reset in the middle of traffic with three waiting entries.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            apply_stimulus(1, 1, 32'(i), 0, 5, 0, 0, 0, 0, 0, 0, 1, 0);
        end
        tick();
        apply_stimulus(1, 1, 32'h9, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        check_output("rst_pre count", 64'(count), 64'd3);
        #1 RST = 1'b1;
        #2 RST = 1'b0;
        #1;
        check_output("rst count", 64'(count), 64'd0);
        check_output("rst empty", 64'(empty), 64'd1);
        check_output("rst full", 64'(full), 64'd0);
        check_output("rst enq_ready", 64'(enq_ready), 64'd1);
        check_output("rst iss_valid", 64'(iss_valid), 64'd0);
        check_output("rst enq_id", 64'(enq_id), 64'd1);
        clear_inputs();

        // Full queue: enqueue and issue together once a tag has been freed.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            apply_stimulus(1, 0, 32'(i + 1), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        tick();
        apply_stimulus(1, 0, 32'h50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_output("full count", 64'(count), 64'd4);
        check_output("full flag", 64'(full), 64'd1);
        check_output("full enq_ready", 64'(enq_ready), 64'd0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(1, 2, 32'h50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_output("full no_iss enq_ready", 64'(enq_ready), 64'd0);
        check_output("full freed enq_id", 64'(enq_id), 64'd1);
        iss_ready = 1'b1;
        #1;
        check_output("full iss enq_ready", 64'(enq_ready), 64'd1);
        check_output("full head iss_id", 64'(iss_id), 64'd1);
        tick();
        clear_inputs();
        #1;
        check_output("full after count", 64'(count), 64'd4);
        check_output("full after iss_id", 64'(iss_id), 64'd2);
        check_output("full after iss_val", 64'(iss_val), 64'd2);

        // Flush with two entries holding ids 1 and 2, then stall accounting.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            apply_stimulus(1, 1, 32'(i), 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        tick();
        apply_stimulus(1, 1, 32'h7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        check_output("flush_pre count", 64'(count), 64'd2);
        tick();
        clear_inputs();
        #1;
        check_output("flush empty", 64'(empty), 64'd1);
        check_output("flush count", 64'(count), 64'd0);
        check_output("flush enq_id", 64'(enq_id), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            apply_stimulus(1, 0, 32'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            apply_stimulus(1, 0, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            check_output($sformatf("stall%0d enq_ready", i), 64'(enq_ready), 64'd0);
        end
        tick();
        clear_inputs();
        #1;
`ifdef IQ_STATS_EN
        check_output("stall_full_cnt", 64'(stall_full_cnt), 64'd3);
`endif
        flush = 1'b1;
        tick();
        clear_inputs();
        #1;
        check_output("flush2 empty", 64'(empty), 64'd1);
`ifdef IQ_STATS_EN
        check_output("stall_full_cnt kept", 64'(stall_full_cnt), 64'd3);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        mq.delete();
        m_busy = '0;
        for (int n = 0; n < 400; n++) begin
            bit          m_free;
            bit          m_iv;
            bit          m_iss;
            bit          m_er;
            bit          m_enq;
            int          m_id;
            int          r0;
            int          r1;
            logic [31:0] d;
            m_entry_t    e;
            tick();
            r0 = $urandom_range(0, 7);
            r1 = $urandom_range(0, 7);
            apply_stimulus($urandom_range(0, 2) != 0, 2'($urandom), $urandom, $urandom,
                           (r0 < 4) ? 4'd0 : 4'(r0), (r1 < 5) ? 4'd0 : 4'(r1),
                           {($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4)},
                           4'($urandom_range(1, 7)), $urandom, 4'($urandom_range(1, 7)), $urandom,
                           $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
            #1;
            m_free = 1'b0;
            m_id   = ID_BASE;
            for (int t = ID_BASE + DEPTH - 1; t >= ID_BASE; t--) begin
                if (!m_busy[t]) begin
                    m_free = 1'b1;
                    m_id   = t;
                end
            end
            m_iv  = (mq.size() > 0) && (mq[0].t == '0);
            m_iss = m_iv && iss_ready && !flush;
            m_er  = m_free && ((mq.size() < DEPTH) || m_iss);
            check_output("rnd count", 64'(count), 64'(mq.size()));
            check_output("rnd empty", 64'(empty), 64'(mq.size() == 0));
            check_output("rnd full", 64'(full), 64'(mq.size() == DEPTH));
            check_output("rnd iss_valid", 64'(iss_valid), 64'(m_iv));
            check_output("rnd enq_ready", 64'(enq_ready), 64'(m_er));
            if (m_free) check_output("rnd enq_id", 64'(enq_id), 64'(m_id));
            if (m_iv) begin
                check_output("rnd iss_op", 64'(iss_op), 64'(mq[0].op));
                check_output("rnd iss_val", 64'(iss_val), 64'(mq[0].v));
                check_output("rnd iss_id", 64'(iss_id), 64'(mq[0].id));
            end
            if (flush) begin
                mq.delete();
                m_busy = '0;
            end else begin
                m_enq = enq_valid && m_er;
                for (int i = 0; i < mq.size(); i++) begin
                    e = mq[i];
                    for (int k = 0; k < NUM_SRC; k++) begin
                        if (m_snoop(e.t[k], d)) begin
                            e.v[k] = d;
                            e.t[k] = '0;
                        end
                    end
                    mq[i] = e;
                end
                if (m_iss) void'(mq.pop_front());
                if (m_enq) begin
                    e.op = enq_op;
                    e.id = 4'(m_id);
                    for (int k = 0; k < NUM_SRC; k++) begin
                        if (m_snoop(enq_tag[k*TAG_W +: TAG_W], d)) begin
                            e.v[k] = d;
                            e.t[k] = '0;
                        end else begin
                            e.v[k] = enq_val[k*DATA_W +: DATA_W];
                            e.t[k] = enq_tag[k*TAG_W +: TAG_W];
                        end
                    end
                    mq.push_back(e);
                end
                for (int c = 0; c < NUM_BC; c++) begin
                    if (bc_valid[c]) m_busy[bc_tag[c*TAG_W +: TAG_W]] = 1'b0;
                end
                if (m_enq) m_busy[m_id] = 1'b1;
            end
        end

        clear_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
